// File: rtl/ps2_cmd_encoder_if.sv
// PS/2 line inputs and the 4-bit command-code outputs of ps2_cmd_encoder.
// master = encoder side, slave = keyboard model plus downstream decoder.
interface ps2_cmd_encoder_if;
    logic       ps2Clk;
    logic       ps2Data;
    logic [3:0] outCode;
    logic       codeValid;
    logic       frameErr;

    // codeValid is a one-clock strobe qualifying outCode (4'hF when low); there is no
    // ready, so the consumer must take every strobe. frameErr is an independent strobe.
    modport master (
        input  ps2Clk,
        input  ps2Data,
        output outCode,
        output codeValid,
        output frameErr
    );

    modport slave (
        output ps2Clk,
        output ps2Data,
        input  outCode,
        input  codeValid,
        input  frameErr
    );
endinterface

// File: rtl/ps2_cmd_encoder.sv
// PS/2 keyboard frame receiver that maps make codes (with E0/F0 prefixes) to 4-bit commands.
// Optional macro TYPEMATIC_FILTER_EN suppresses auto-repeated makes of the last key.
module ps2_cmd_encoder #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 50000,
    parameter int TO_W        = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    ps2_cmd_encoder_if.master        bus,
    output logic [1:0]               o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_CHECK  = 2'd2,
        S_DECODE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;
    logic [3:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par;
    logic                   r_stop;
    logic [TO_W-1:0]        r_to_cnt;
    logic                   w_timeout;
    logic                   r_ext;
    logic                   r_brk;
    logic                   w_ext_next;
    logic                   w_brk_next;
    logic                   w_err;
    logic [3:0]             w_code;
    logic [8:0]             w_key;
    logic [3:0]             r_out_code;
    logic                   r_code_valid;
    logic                   r_frame_err;
`ifdef TYPEMATIC_FILTER_EN
    logic [8:0]             r_last;
    logic                   r_last_vld;
    logic [8:0]             w_last_next;
    logic                   w_last_vld_next;
`endif

    function automatic logic [3:0] map_make(input logic [8:0] key);
        logic [3:0] code;
        case (key)
            9'h045:  code = 4'h0;
            9'h016:  code = 4'h1;
            9'h01E:  code = 4'h2;
            9'h026:  code = 4'h3;
            9'h02D:  code = 4'h4;
            9'h034:  code = 4'h5;
            9'h032:  code = 4'h6;
            9'h175:  code = 4'h7;
            9'h172:  code = 4'h8;
            9'h16B:  code = 4'h9;
            9'h174:  code = 4'hA;
            9'h079:  code = 4'hB;
            9'h07B:  code = 4'hC;
            9'h042:  code = 4'hD;
            9'h02B:  code = 4'hE;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    // Both lines preset high so a reset never looks like a falling edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], bus.ps2Clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], bus.ps2Data};
            r_clk_prev  <= w_clk_s;
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_prev & ~w_clk_s;
    assign w_key    = {r_ext, r_shift};

    // Saturating idle counter; only consulted while a frame is in progress.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_fall) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_SHIFT) && !w_fall && (r_to_cnt >= TO_W'(TIMEOUT_CYC));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_stop    <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_bit_cnt <= '0;
        end else if (r_state == S_SHIFT && w_fall) begin
            if (r_bit_cnt < 4'd8) begin
                r_shift <= {w_data_s, r_shift[7:1]};
            end else if (r_bit_cnt == 4'd8) begin
                r_par <= w_data_s;
            end else begin
                r_stop <= w_data_s;
            end
            r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_err        = 1'b0;
        w_code       = 4'hF;
        w_ext_next   = r_ext;
        w_brk_next   = r_brk;
`ifdef TYPEMATIC_FILTER_EN
        w_last_next     = r_last;
        w_last_vld_next = r_last_vld;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_fall && !w_data_s) begin
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_timeout) begin
                    w_err        = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_fall && r_bit_cnt == 4'd9) begin
                    w_state_next = S_CHECK;
                end
            end
            S_CHECK: begin
                // Odd parity: data ones plus parity bit must be odd.
                if (((^r_shift) ^ r_par) != 1'b1 || !r_stop) begin
                    w_err        = 1'b1;
                    w_ext_next   = 1'b0;
                    w_brk_next   = 1'b0;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_next = S_IDLE;
                if (r_shift == 8'hE0) begin
                    w_ext_next = 1'b1;
                end else if (r_shift == 8'hF0) begin
                    w_brk_next = 1'b1;
                end else begin
                    w_ext_next = 1'b0;
                    w_brk_next = 1'b0;
                    if (!r_brk) begin
`ifdef TYPEMATIC_FILTER_EN
                        if (!(r_last_vld && r_last == w_key)) begin
                            w_code = map_make(w_key);
                        end
                        w_last_next     = w_key;
                        w_last_vld_next = 1'b1;
`else
                        w_code = map_make(w_key);
`endif
                    end
`ifdef TYPEMATIC_FILTER_EN
                    else if (r_last_vld && r_last == w_key) begin
                        w_last_vld_next = 1'b0;
                    end
`endif
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ext        <= 1'b0;
            r_brk        <= 1'b0;
            r_out_code   <= 4'hF;
            r_code_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_ext        <= w_ext_next;
            r_brk        <= w_brk_next;
            r_out_code   <= w_code;
            r_code_valid <= (w_code != 4'hF);
            r_frame_err  <= w_err;
        end
    end

`ifdef TYPEMATIC_FILTER_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last     <= '0;
            r_last_vld <= 1'b0;
        end else begin
            r_last     <= w_last_next;
            r_last_vld <= w_last_vld_next;
        end
    end
`endif

    assign bus.outCode   = r_out_code;
    assign bus.codeValid = r_code_valid;
    assign bus.frameErr  = r_frame_err;
    assign o_dbg_state   = r_state;

endmodule
